fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_pkg.sv | 15 +
 rtl/sat_counter16.sv | 19 +
 rtl/fetch_stage.sv | 108 ++++++++++
 tb/tb_fetch_stage.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and FSM state type for the instruction fetch stage.
package fetch_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] DEFAULT_HALT_INSTR = 32'h0000_000C;
    localparam logic [31:0] NOP_INSTR          = 32'h0000_0000;
    localparam logic [15:0] CNT_MAX            = 16'hFFFF;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

endpackage

// File: rtl/sat_counter16.sv
// 16-bit event counter that sticks at its maximum instead of wrapping; async active-low clear.
module sat_counter16
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [15:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 16'h0000;
        end else if (en && (count != CNT_MAX)) begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register, halt FSM.
// Define FETCH_STATS_EN to build the fetch/flush/stall statistics counters.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter logic [31:0] HALT_INSTR = DEFAULT_HALT_INSTR
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pcen,
    input  logic        pcclear,
    input  logic [31:0] newpc,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] imem_addr,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_instr,
    output logic        ifid_valid,
    output logic        halted,
    output logic        misalign,
    output logic [15:0] fetchcnt,
    output logic [15:0] flushcnt,
    output logic [15:0] stallcnt
);

    state_t state;
    state_t nextstate;
    logic   haltdet;

    // The halting cycle freezes everything so the halt word stays visible for one HALT cycle.
    assign haltdet   = (state == RUN) && ifid_valid && (ifid_instr == HALT_INSTR);
    assign imem_addr = pc;
    assign halted    = (state == HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT;
        end else begin
            state <= nextstate;
        end
    end

    always_comb begin
        nextstate = state;
        case (state)
            BOOT:    nextstate = RUN;
            RUN:     if (haltdet) nextstate = HALT;
            HALT:    nextstate = HALT;
            default: nextstate = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= RESET_PC;
            ifid_pc    <= 32'h0;
            ifid_instr <= NOP_INSTR;
            ifid_valid <= 1'b0;
            misalign   <= 1'b0;
        end else if (state == RUN) begin
            if (!haltdet) begin
                if (pcen) begin
                    pc <= newpc;
                    if (newpc[1:0] != 2'b00) begin
                        misalign <= 1'b1;
                    end
                end
                // Flush wins over stall: a redirect always squashes the fetched word.
                if (pcclear) begin
                    ifid_pc    <= 32'h0;
                    ifid_instr <= NOP_INSTR;
                    ifid_valid <= 1'b0;
                end else if (pcen) begin
                    ifid_pc    <= pc;
                    ifid_instr <= imem_rdata;
                    ifid_valid <= 1'b1;
                end
            end
        end else begin
            ifid_pc    <= 32'h0;
            ifid_instr <= NOP_INSTR;
            ifid_valid <= 1'b0;
        end
    end

`ifdef FETCH_STATS_EN
    logic run;
    logic fetchen;
    logic flushen;
    logic stallen;

    assign run     = (state == RUN) && !haltdet;
    assign fetchen = run && pcen && !pcclear;
    assign flushen = run && pcclear;
    assign stallen = run && !pcen && !pcclear;

    sat_counter16 u_fetchcnt (.clk(clk), .rst_n(rst_n), .en(fetchen), .count(fetchcnt));
    sat_counter16 u_flushcnt (.clk(clk), .rst_n(rst_n), .en(flushen), .count(flushcnt));
    sat_counter16 u_stallcnt (.clk(clk), .rst_n(rst_n), .en(stallen), .count(stallcnt));
`else
    assign fetchcnt = 16'h0000;
    assign flushcnt = 16'h0000;
    assign stallcnt = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; counter expectations follow FETCH_STATS_EN.
module tb_fetch_stage;

`ifdef FETCH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        pcen;
    logic        pcclear;
    logic [31:0] newpc;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] imem_addr;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_instr;
    logic        ifid_valid;
    logic        halted;
    logic        misalign;
    logic [15:0] fetchcnt;
    logic [15:0] flushcnt;
    logic [15:0] stallcnt;

    logic        autoInc;
    logic [31:0] newpcReg;
    logic [31:0] haltAddr;
    int          testCount;
    int          failCount;

    fetch_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pcen       (pcen),
        .pcclear    (pcclear),
        .newpc      (newpc),
        .imem_rdata (imem_rdata),
        .pc         (pc),
        .imem_addr  (imem_addr),
        .ifid_pc    (ifid_pc),
        .ifid_instr (ifid_instr),
        .ifid_valid (ifid_valid),
        .halted     (halted),
        .misalign   (misalign),
        .fetchcnt   (fetchcnt),
        .flushcnt   (flushcnt),
        .stallcnt   (stallcnt)
    );

    // Instruction memory: halt word at haltAddr, otherwise an address-tagged pattern.
    assign imem_rdata = (imem_addr == haltAddr) ? 32'h0000_000C : (imem_addr ^ 32'hABCD_0000);
    assign newpc      = autoInc ? (pc + 32'd4) : newpcReg;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic clr, input logic inc, input logic [31:0] np);
        pcen     = en;
        pcclear  = clr;
        autoInc  = inc;
        newpcReg = np;
        @(posedge clk);
        #1;
    endtask

    task automatic checkIfid(input string tag, input logic [31:0] epc, input logic [31:0] einstr, input logic evalid);
        checkOutput({tag, ".ifid_pc"}, ifid_pc, epc);
        checkOutput({tag, ".ifid_instr"}, ifid_instr, einstr);
        checkOutput({tag, ".ifid_valid"}, {31'h0, ifid_valid}, {31'h0, evalid});
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, ".pc"}, pc, 32'h0000_3000);
        checkOutput({tag, ".imem_addr"}, imem_addr, 32'h0000_3000);
        checkIfid(tag, 32'h0, 32'h0, 1'b0);
        checkOutput({tag, ".halted"}, {31'h0, halted}, 32'h0);
        checkOutput({tag, ".misalign"}, {31'h0, misalign}, 32'h0);
        checkOutput({tag, ".fetchcnt"}, {16'h0, fetchcnt}, 32'h0);
        checkOutput({tag, ".flushcnt"}, {16'h0, flushcnt}, 32'h0);
        checkOutput({tag, ".stallcnt"}, {16'h0, stallcnt}, 32'h0);
    endtask

    function automatic logic [31:0] cnt(input int n);
        return STATS ? 32'(n) : 32'h0;
    endfunction

    initial begin
        testCount = 0;
        failCount = 0;
        rst_n     = 1'b1;
        pcen      = 1'b1;
        pcclear   = 1'b0;
        autoInc   = 1'b1;
        newpcReg  = 32'h0;
        haltAddr  = 32'hFFFF_FFF0;

        // Power-on reset and boot sequence.
        #2 rst_n = 1'b0;
        #1 checkReset("reset");
        @(negedge clk) rst_n = 1'b1;

        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0);
        checkOutput("boot.pc", pc, 32'h0000_3000);
        checkIfid("boot", 32'h0, 32'h0, 1'b0);

        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0);
        checkOutput("run1.pc", pc, 32'h0000_3004);
        checkIfid("run1", 32'h0000_3000, 32'hABCD_3000, 1'b1);
        checkOutput("run1.fetchcnt", {16'h0, fetchcnt}, cnt(1));

        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0);
        checkOutput("run2.pc", pc, 32'h0000_3008);
        checkIfid("run2", 32'h0000_3004, 32'hABCD_3004, 1'b1);
        checkOutput("run2.fetchcnt", {16'h0, fetchcnt}, cnt(2));

        // Two stall cycles hold PC and IF/ID.
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0);
        checkOutput("stall.pc", pc, 32'h0000_3008);
        checkIfid("stall", 32'h0000_3004, 32'hABCD_3004, 1'b1);
        checkOutput("stall.stallcnt", {16'h0, stallcnt}, cnt(2));
        checkOutput("stall.fetchcnt", {16'h0, fetchcnt}, cnt(2));

        // Flush while stalled: bubble, PC held; then redirect target loads.
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0000_3040);
        checkOutput("flush.pc", pc, 32'h0000_3008);
        checkIfid("flush", 32'h0, 32'h0, 1'b0);
        checkOutput("flush.flushcnt", {16'h0, flushcnt}, cnt(1));

        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0000_3040);
        checkOutput("redirect.pc", pc, 32'h0000_3040);
        checkIfid("redirect", 32'h0000_3008, 32'hABCD_3008, 1'b1);
        checkOutput("redirect.fetchcnt", {16'h0, fetchcnt}, cnt(3));

        // Misaligned target loads unchanged and sets the sticky flag.
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0000_3002);
        checkOutput("misal.pc", pc, 32'h0000_3002);
        checkOutput("misal.flag", {31'h0, misalign}, 32'h1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0000_3044);
        checkOutput("misal2.pc", pc, 32'h0000_3044);
        checkOutput("misal2.flag", {31'h0, misalign}, 32'h1);
        checkIfid("misal2", 32'h0000_3002, 32'hABCD_3002, 1'b1);
        checkOutput("misal2.fetchcnt", {16'h0, fetchcnt}, cnt(5));
        checkOutput("misal2.flushcnt", {16'h0, flushcnt}, cnt(1));

        // Asynchronous reset in the middle of a stall cycle.
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0000_3100);
        checkOutput("prereset.stallcnt", {16'h0, stallcnt}, cnt(3));
        #2 rst_n = 1'b0;
        #1 checkReset("midreset");
        @(negedge clk) rst_n = 1'b1;

        // Halt: halt word sits at 3008.
        haltAddr = 32'h0000_3008;
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0);
        checkOutput("hboot.pc", pc, 32'h0000_3000);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0);
        checkOutput("hfetch.pc", pc, 32'h0000_300C);
        checkIfid("hfetch", 32'h0000_3008, 32'h0000_000C, 1'b1);
        checkOutput("hfetch.halted", {31'h0, halted}, 32'h0);

        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0);
        checkOutput("hfirst.halted", {31'h0, halted}, 32'h1);
        checkOutput("hfirst.pc", pc, 32'h0000_300C);
        checkIfid("hfirst", 32'h0000_3008, 32'h0000_000C, 1'b1);

        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0000_3100);
        checkOutput("hold1.pc", pc, 32'h0000_300C);
        checkIfid("hold1", 32'h0, 32'h0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_3200);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0000_3300);
        checkOutput("hold2.pc", pc, 32'h0000_300C);
        checkOutput("hold2.halted", {31'h0, halted}, 32'h1);
        checkOutput("hold2.fetchcnt", {16'h0, fetchcnt}, cnt(3));
        checkOutput("hold2.flushcnt", {16'h0, flushcnt}, cnt(0));
        checkOutput("hold2.stallcnt", {16'h0, stallcnt}, cnt(0));

        // Reset out of HALT, then saturate the stall counter.
        @(negedge clk) rst_n = 1'b0;
        #1 checkReset("haltreset");
        haltAddr = 32'hFFFF_FFF0;
        @(negedge clk) rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0000_3100);
        for (int i = 0; i < 65540; i++) begin
            @(posedge clk);
        end
        #1;
        checkOutput("sat.stallcnt", {16'h0, stallcnt}, STATS ? 32'h0000_FFFF : 32'h0);
        checkOutput("sat.fetchcnt", {16'h0, fetchcnt}, cnt(0));
        checkOutput("sat.pc", pc, 32'h0000_3000);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
